// File: rtl/logic_op_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_op_sched_if : requester/arbiter bundle for the shared logic unit
// Revision: 1.0
// ---------------------------------------------------------------------------
interface logic_op_sched_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [1:0]       op0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport master (
    output req0, op0, a0, b0, req1, op1, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy
  );

  modport slave (
    input  req0, op0, a0, b0, req1, op1, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy
  );
endinterface
`default_nettype wire

// File: rtl/logic_op_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// logic_op_sched : round-robin sequencer sharing one AND/OR/XOR/NOT unit
// Revision: 1.0
// ---------------------------------------------------------------------------
module logic_op_sched #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  logic_op_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             served;
  logic             served_next;
  logic             last_served;
  logic             capture;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] alu_out;

  // Requests are only looked at in IDLE; a tie goes to whoever was not served last.
  always_comb begin
    state_next  = state;
    served_next = served;
    capture     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          capture    = 1'b1;
          state_next = EXEC;
          if (bus.req0 && bus.req1) begin
            served_next = ~last_served;
          end else begin
            served_next = bus.req1;
          end
        end
      end
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_out = '0;
    case (op_q)
      2'b00:   alu_out = a_q & b_q;
      2'b01:   alu_out = a_q | b_q;
      2'b10:   alu_out = a_q ^ b_q;
      default: alu_out = ~a_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      served      <= 1'b0;
      last_served <= 1'b1;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
    end else begin
      state  <= state_next;
      served <= served_next;
      if (capture) begin
        op_q <= served_next ? bus.op1 : bus.op0;
        a_q  <= served_next ? bus.a1  : bus.a0;
        b_q  <= served_next ? bus.b1  : bus.b0;
      end
      if (state == EXEC) begin
        result_q <= alu_out;
      end
      if (state == DONE) begin
        last_served <= served;
      end
    end
  end

  assign bus.gnt0   = (state == EXEC) && !served;
  assign bus.gnt1   = (state == EXEC) &&  served;
  assign bus.done0  = (state == DONE) && !served;
  assign bus.done1  = (state == DONE) &&  served;
  assign bus.busy   = (state != IDLE);
  assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_logic_op_sched : table-driven bench with a result scoreboard
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_logic_op_sched;

  typedef struct {
    logic       who;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
  } vec_t;

  typedef struct {
    logic       who;
    logic [3:0] exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  sb_t  sbq[$];
  vec_t vecs[8];

  logic_op_sched_if #(.WIDTH(4)) bus ();

  logic_op_sched #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding request.
  sb_t e;
  always @(negedge clk) begin
    if (!rst && (bus.done0 || bus.done1)) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("done_who",  {31'd0, bus.done1}, {31'd0, e.who});
        check("done_both", {31'd0, bus.done0 & bus.done1}, 32'd0);
        check("result",    {28'd0, bus.result}, {28'd0, e.exp});
      end
    end
  end

  task automatic drive_req(input vec_t v);
    if (!v.who) begin
      bus.req0 = 1'b1; bus.op0 = v.op; bus.a0 = v.a; bus.b0 = v.b;
    end else begin
      bus.req1 = 1'b1; bus.op1 = v.op; bus.a1 = v.a; bus.b1 = v.b;
    end
  endtask

  // Called in an IDLE cycle at negedge; returns at the next IDLE negedge.
  task automatic do_op(input vec_t v);
    sbq.push_back('{v.who, v.exp});
    drive_req(v);
    @(negedge clk);
    check("gnt0_exec", {31'd0, bus.gnt0}, {31'd0, !v.who});
    check("gnt1_exec", {31'd0, bus.gnt1}, {31'd0, v.who});
    check("busy_exec", {31'd0, bus.busy}, 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    // Scramble the inputs after capture; the in-flight result must not move.
    if (!v.who) begin
      bus.a0 = ~v.a; bus.b0 = ~v.b; bus.op0 = v.op ^ 2'b01;
    end else begin
      bus.a1 = ~v.a; bus.b1 = ~v.b; bus.op1 = v.op ^ 2'b01;
    end
    @(negedge clk);
    check("done_pulse", {31'd0, v.who ? bus.done1 : bus.done0}, 32'd1);
    check("busy_done",  {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    check("idle_pulses", {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req0 = 1'b0; bus.op0 = 2'b00; bus.a0 = 4'h0; bus.b0 = 4'h0;
    bus.req1 = 1'b0; bus.op1 = 2'b00; bus.a1 = 4'h0; bus.b1 = 4'h0;

    vecs[0] = '{1'b0, 2'b00, 4'b0001, 4'b0101, 4'b0001};
    vecs[1] = '{1'b1, 2'b01, 4'b1111, 4'b1101, 4'b1111};
    vecs[2] = '{1'b1, 2'b10, 4'b1111, 4'b1101, 4'b0010};
    vecs[3] = '{1'b1, 2'b11, 4'b1111, 4'b1101, 4'b0000};
    vecs[4] = '{1'b0, 2'b10, 4'b1010, 4'b0110, 4'b1100};
    vecs[5] = '{1'b0, 2'b11, 4'b0101, 4'b1111, 4'b1010};
    vecs[6] = '{1'b1, 2'b00, 4'b1100, 4'b1010, 4'b1000};
    vecs[7] = '{1'b0, 2'b01, 4'b0001, 4'b1000, 4'b1001};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pulses", {28'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 32'd0);
    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("rst_result", {28'd0, bus.result}, 32'd0);
    rst = 1'b0;

    // Held tie after reset: order 0,1,0,1 with one IDLE cycle between.
    bus.op0 = 2'b00; bus.a0 = 4'b0011; bus.b0 = 4'b0101;
    bus.op1 = 2'b01; bus.a1 = 4'b0011; bus.b1 = 4'b0101;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back('{i[0], i[0] ? 4'b0111 : 4'b0001});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tie_gnt0", {31'd0, bus.gnt0}, {31'd0, !i[0]});
      check("tie_gnt1", {31'd0, bus.gnt1}, {31'd0, i[0]});
      if (i == 3) begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
      end
      @(negedge clk);
      check("tie_busy_done", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      check("tie_busy_idle", {31'd0, bus.busy}, 32'd0);
    end

    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i]);
    end

    // Operand hold: a0 goes 1111 -> 0000 in the grant cycle.
    do_op('{1'b0, 2'b00, 4'b1111, 4'b1101, 4'b1101});

    // Reset in EXEC of a requester-1 transaction.
    bus.req1 = 1'b1; bus.op1 = 2'b10; bus.a1 = 4'b0110; bus.b1 = 4'b0011;
    @(negedge clk);
    check("mid_gnt1", {31'd0, bus.gnt1}, 32'd1);
    rst = 1'b1;
    bus.req1 = 1'b0;
    @(negedge clk);
    check("mid_done1",  {31'd0, bus.done1}, 32'd0);
    check("mid_busy",   {31'd0, bus.busy}, 32'd0);
    check("mid_result", {28'd0, bus.result}, 32'd0);
    rst = 1'b0;

    // First tie after reset goes to requester 0.
    sbq.push_back('{1'b0, 4'b1001});
    bus.op0 = 2'b11; bus.a0 = 4'b0110; bus.b0 = 4'b1111;
    bus.op1 = 2'b00; bus.a1 = 4'b1111; bus.b1 = 4'b1111;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    @(negedge clk);
    check("post_rst_gnt0", {31'd0, bus.gnt0}, 32'd1);
    check("post_rst_gnt1", {31'd0, bus.gnt1}, 32'd0);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    check("post_rst_done0", {31'd0, bus.done0}, 32'd1);
    @(negedge clk);

    // Idle stability
    for (int i = 0; i < 10; i++) begin
      check("idle_pulses_hold", {27'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy}, 32'd0);
      check("idle_result_hold", {28'd0, bus.result}, {28'd0, 4'b1001});
      @(negedge clk);
    end

    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logic_op_sched.md
# logic_op_sched

Sequencer and round-robin arbiter that shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters. Each requester presents an opcode and two operands; the block grants one requester at a time, latches its operands, evaluates the operation in a registered stage and returns the result with a per-requester done pulse. It sits between the binary-logic datapath and the step-level control that issues logic operations.

## Interface
- WIDTH, 4, operand/result width in bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request (level)
- op0  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOT a (b ignored)
- a0, b0  input  WIDTH  requester 0 operands
- req1, op1, a1, b1  input  1/2/WIDTH/WIDTH  same for requester 1
- gnt0, gnt1  output  1  one-cycle grant pulse; operands latched this cycle
- done0, done1  output  1  one-cycle completion pulse; result valid this cycle
- result  output  WIDTH  shared result bus
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE: reqX sampled only here. No request -> stay IDLE. One request -> serve it. Both -> serve requester != last_served. Next state EXEC; winner's op/a/b captured into internal registers at the same edge.
- EXEC: gntX high for the served requester; logic unit evaluates latched op/a/b; result register loaded at end of cycle. Next state DONE.
- DONE: doneX high for the served requester; result holds computed value; last_served updated to served requester at end of cycle. Next state IDLE.
- result holds its last value until the next DONE overwrite; never changes outside a DONE load.
- Operand/opcode changes on the inputs after capture have no effect on the transaction in flight.
- Requester protocol: hold reqX until gntX seen; deassert by the cycle after doneX unless another operation is wanted. A req still high in the IDLE cycle after DONE is a new request.
- NOT: result = ~a; b is don't-care.
- No overflow/width issues: all operations bitwise, WIDTH in, WIDTH out.

## Timing
- Reset values: gnt0=gnt1=done0=done1=0, busy=0, result=0, state=IDLE, last_served=1 (requester 0 wins the first tie).
- Latency: req sampled at end of cycle N (IDLE) -> gnt in N+1 -> done + result in N+2 -> IDLE in N+3.
- Throughput: one operation per 3 cycles; continuous requests from both sides alternate 0,1,0,1.
- Exactly one of gnt0/gnt1 high in EXEC, exactly one of done0/done1 in DONE; never both; all zero in IDLE.
- busy high in EXEC and DONE only.
- req edges during EXEC/DONE ignored (not queued); only level in IDLE counts.
- rst during EXEC or DONE: transaction dropped, no done pulse issued, all outputs and last_served return to reset values on the next cycle.
- rst has priority over every other transition.

## Test plan
- Single AND: req0=1, op0=00, a0=0001, b0=0101 in IDLE -> gnt0 next cycle, done0 one cycle later with result=0001; gnt1/done1 stay 0.
- Requester 1 ops: op1=01 a1=1111 b1=1101 -> result=1111; op1=10 -> 0010; op1=11 -> 0000 (b ignored); each done1 exactly 2 cycles after acceptance.
- Simultaneous requests held high after reset: req0=req1=1 -> service order 0,1,0,1; grants spaced 3 cycles; busy low for exactly the IDLE cycle between transactions.
- Operand hold: change a0 from 1111 to 0000 in the gnt0 cycle of an AND with b0=1101 -> result=1101 (captured values used).
- Reset mid-operation: assert rst in EXEC of a requester-1 transaction -> no done1 pulse, result=0, busy=0; next tie after reset granted to requester 0.
- Idle stability: no requests for 10 cycles -> all outputs 0, result unchanged from last value.
